// File: rtl/vs10xx_stream_ctrl.sv
// vs10xx_stream_ctrl
//   VS10xx MP3 decoder driver. Hardware-resets the codec, sends the SCI init
//   sequence (mode reset, volume, mode run) and then streams one of NUM_TRACKS
//   ROM-resident tracks over SDI. Volume changes are written between frames.
//   Supports pause and wraps at the end of a track with a one-cycle done pulse.
// Ports
//   clk, RST        system clock, synchronous active-low reset
//   track_sel       selected track (out-of-range values play track 0)
//   pause           level, stops streaming after the current frame
//   vol             SCI_VOL value {left, right}
//   mem_addr        ROM address shared by all tracks
//   mem_data        ROM outputs, track k at [k*WORD_W +: WORD_W], 1-cycle latency
//   MP3_RST         codec xRESET (active-low)
//   MP3_CS/MP3_DCS  codec SCI/SDI selects (active-low)
//   MP3_MOSI        serial data, MSB first
//   MP3_SCLK        serial clock, idle low
//   MP3_DREQ        codec data request (asynchronous)
//   track_done      one-cycle pulse after the last word of a track is sent
//   busy            high unless idle or paused
module vs10xx_stream_ctrl #(
    parameter int unsigned NUM_TRACKS  = 7,
    parameter int unsigned TRK_W       = 3,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned TRACK_WORDS = 131072,
    parameter int unsigned SCLK_DIV    = 50,
    parameter int unsigned RST_HOLD    = 1000000,
    parameter logic [15:0] MODE_RESET  = 16'h0804,
    parameter logic [15:0] MODE_RUN    = 16'h0800
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic [TRK_W-1:0]             track_sel,
    input  logic                         pause,
    input  logic [15:0]                  vol,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [NUM_TRACKS*WORD_W-1:0] mem_data,
    output logic                         MP3_RST,
    output logic                         MP3_CS,
    output logic                         MP3_DCS,
    output logic                         MP3_MOSI,
    output logic                         MP3_SCLK,
    input  logic                         MP3_DREQ,
    output logic                         track_done,
    output logic                         busy
);

    localparam int unsigned SH_W   = (WORD_W > 32) ? WORD_W : 32;
    localparam int unsigned HALF_W = $clog2(2 * SH_W + 1);
    localparam int unsigned DIV_W  = $clog2(SCLK_DIV);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TRACK_WORDS - 1);
    localparam logic [HALF_W-1:0] SCI_HALVES = HALF_W'(64);
    localparam logic [HALF_W-1:0] SDI_HALVES = HALF_W'(2 * WORD_W);

    typedef enum logic [2:0] {
        HWRST,
        WAITREQ,
        INIT,
        IDLE,
        PAUSED,
        XFER,
        GAP
    } state_t;

    state_t state, state_n;

    logic [TRK_W-1:0]  trk_q;
    logic              trk_chg;
    logic              dreq_meta, dreq_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic [SH_W-1:0]   shreg;
    logic              is_sdi;
    logic [1:0]        init_idx;
    logic [15:0]       vol_shadow;
    logic [WORD_W-1:0] rom_word;
    logic [31:0]       sci_word;
    logic              start_sci, start_sdi, vol_take;
    logic              div_end, frame_end, vol_pend;

    // A track change restarts the codec exactly like RST, keeping the volume.
    assign trk_chg   = (track_sel != trk_q);
    assign vol_pend  = (vol != vol_shadow);
    assign div_end   = (div_cnt == DIV_LAST);
    assign frame_end = (state == XFER) && div_end &&
                       (half_cnt == (is_sdi ? SDI_HALVES : SCI_HALVES));

    always_comb begin
        int unsigned sel;
        sel      = (32'(trk_q) < NUM_TRACKS) ? 32'(trk_q) : 0;
        rom_word = '0;
        for (int unsigned k = 0; k < NUM_TRACKS; k++) begin
            if (sel == k) rom_word = mem_data[k*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        trk_q <= track_sel;
        if (!RST) begin
            dreq_meta <= 1'b0;
            dreq_s    <= 1'b0;
        end else begin
            dreq_meta <= MP3_DREQ;
            dreq_s    <= dreq_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!RST || trk_chg) state <= HWRST;
        else                 state <= state_n;
    end

    // Next-state logic and frame launch decisions
    always_comb begin
        state_n   = state;
        start_sci = 1'b0;
        start_sdi = 1'b0;
        vol_take  = 1'b0;
        sci_word  = '0;
        case (state)
            HWRST:   if (hold_cnt == HOLD_LAST) state_n = WAITREQ;
            WAITREQ: if (dreq_s) state_n = INIT;
            INIT: begin
                if (dreq_s) begin
                    start_sci = 1'b1;
                    state_n   = XFER;
                    case (init_idx)
                        2'd0:    sci_word = {8'h02, 8'h00, MODE_RESET};
                        2'd1:    sci_word = {8'h02, 8'h0B, vol_shadow};
                        default: sci_word = {8'h02, 8'h00, MODE_RUN};
                    endcase
                end
            end
            IDLE: begin
                if (vol_pend) begin
                    start_sci = 1'b1;
                    vol_take  = 1'b1;
                    sci_word  = {8'h02, 8'h0B, vol};
                    state_n   = XFER;
                end else if (pause) begin
                    state_n = PAUSED;
                end else if (dreq_s) begin
                    start_sdi = 1'b1;
                    state_n   = XFER;
                end
            end
            PAUSED: begin
                if (vol_pend) begin
                    start_sci = 1'b1;
                    vol_take  = 1'b1;
                    sci_word  = {8'h02, 8'h0B, vol};
                    state_n   = XFER;
                end else if (!pause) begin
                    state_n = IDLE;
                end
            end
            XFER: if (frame_end) state_n = GAP;
            // init_idx reaches 3 only once the last init write has launched
            GAP:  if (div_end) state_n = (init_idx == 2'd3) ? IDLE : INIT;
            default: state_n = HWRST;
        endcase
    end

    // Datapath: reset hold counter, bit timing, shifter, ROM address
    always_ff @(posedge clk) begin
        if (!RST || trk_chg) begin
            hold_cnt   <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            shreg      <= '0;
            is_sdi     <= 1'b0;
            init_idx   <= '0;
            mem_addr   <= '0;
            track_done <= 1'b0;
        end else begin
            track_done <= 1'b0;
            if (state == HWRST) hold_cnt <= hold_cnt + HOLD_W'(1);
            if (start_sci || start_sdi) begin
                div_cnt  <= '0;
                half_cnt <= '0;
                is_sdi   <= start_sdi;
                // Left-align the word so the MSB is always at the shifter top.
                shreg    <= start_sdi ? (SH_W'(rom_word) << (SH_W - WORD_W))
                                      : (SH_W'(sci_word) << (SH_W - 32));
                if (state == INIT) init_idx <= init_idx + 2'd1;
            end else if (state == XFER) begin
                if (div_end) begin
                    div_cnt <= '0;
                    if (frame_end) half_cnt <= '0;
                    else           half_cnt <= half_cnt + HALF_W'(1);
                    // Odd halves are SCLK high; leaving one is the falling edge.
                    if (half_cnt[0]) shreg <= shreg << 1;
                    if (frame_end && is_sdi) begin
                        if (mem_addr == LAST_ADDR) begin
                            mem_addr   <= '0;
                            track_done <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else if (state == GAP) begin
                div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST)                     vol_shadow <= 16'hF0F0;
        else if (vol_take && !trk_chg) vol_shadow <= vol;
    end

    // Output decode
    always_comb begin
        MP3_RST  = 1'b1;
        MP3_CS   = 1'b1;
        MP3_DCS  = 1'b1;
        MP3_SCLK = 1'b0;
        MP3_MOSI = 1'b0;
        busy     = 1'b1;
        case (state)
            HWRST: MP3_RST = 1'b0;
            XFER: begin
                MP3_CS   = is_sdi;
                MP3_DCS  = !is_sdi;
                MP3_SCLK = half_cnt[0];
                MP3_MOSI = shreg[SH_W-1];
            end
            IDLE, PAUSED: busy = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vs10xx_stream_ctrl.sv
`timescale 1ns/1ps
module tb_vs10xx_stream_ctrl;

    localparam int unsigned NT   = 7;
    localparam int unsigned WW   = 32;
    localparam int unsigned AW   = 17;
    localparam int unsigned TW   = 4;
    localparam int unsigned DIV  = 2;
    localparam int unsigned HOLD = 10;

    logic            clk = 1'b0;
    logic            RST = 1'b0;
    logic [2:0]      track_sel = 3'd2;
    logic            pause = 1'b0;
    logic [15:0]     vol = 16'hF0F0;
    logic [AW-1:0]   mem_addr;
    logic [NT*WW-1:0] mem_data = '0;
    logic            MP3_RST, MP3_CS, MP3_DCS, MP3_MOSI, MP3_SCLK;
    logic            MP3_DREQ = 1'b0;
    logic            track_done, busy;

    always #5 clk = ~clk;

    vs10xx_stream_ctrl #(
        .NUM_TRACKS(NT), .TRK_W(3), .ADDR_W(AW), .WORD_W(WW),
        .TRACK_WORDS(TW), .SCLK_DIV(DIV), .RST_HOLD(HOLD),
        .MODE_RESET(16'h0804), .MODE_RUN(16'h0800)
    ) dut (
        .clk(clk), .RST(RST), .track_sel(track_sel), .pause(pause), .vol(vol),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .MP3_RST(MP3_RST), .MP3_CS(MP3_CS), .MP3_DCS(MP3_DCS),
        .MP3_MOSI(MP3_MOSI), .MP3_SCLK(MP3_SCLK), .MP3_DREQ(MP3_DREQ),
        .track_done(track_done), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { logic sdi; logic [31:0] data; int bits; } frame_t;
    frame_t obs[$];
    frame_t exp_q[$];

    function automatic logic [31:0] rom(int unsigned k, int unsigned a);
        if (k == 2) return 32'hA5A5_0001 + a;
        return {8'h5A, k[7:0], a[15:0] + 16'd1};
    endfunction

    // ROM model, one-cycle read latency
    always @(posedge clk)
        for (int k = 0; k < NT; k++) mem_data[k*WW +: WW] <= rom(k, 32'(mem_addr));

    // Pin monitor: decodes frames on rising SCLK, checks framing and timing
    int   started = 0, sclk_rises = 0, done_cnt = 0;
    int   proto_err = 0, timing_err = 0;
    int   cyc = 0, lead = -1, last_fall = 0, bits = 0, gap = 0;
    logic prev_sel = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic cur_sdi = 1'b0, seen_frame = 1'b0;
    logic [31:0] cur = '0;

    always @(negedge clk) begin
        logic   sel;
        frame_t f;
        sel = !MP3_CS || !MP3_DCS;
        if (!MP3_CS && !MP3_DCS) proto_err++;
        if (MP3_SCLK && !sel) proto_err++;
        if (MP3_SCLK && prev_sclk && MP3_MOSI !== prev_mosi) proto_err++;
        if (MP3_SCLK && !prev_sclk) sclk_rises++;
        if (track_done) done_cnt++;
        if (sel && !prev_sel) begin
            if (seen_frame && gap < DIV) timing_err++;
            cur_sdi = !MP3_DCS; cur = '0; bits = 0; cyc = 0; lead = -1;
            started++;
        end
        if (sel) begin
            if (MP3_SCLK && !prev_sclk) begin
                cur = {cur[30:0], MP3_MOSI};
                bits++;
                if (lead < 0) lead = cyc;
            end
            if (!MP3_SCLK && prev_sclk) last_fall = cyc;
            cyc++;
        end
        if (!sel && prev_sel) begin
            if (MP3_RST) begin
                if (lead != DIV || cyc - last_fall != DIV) timing_err++;
                f.sdi = cur_sdi; f.data = cur; f.bits = bits;
                obs.push_back(f);
                seen_frame = 1'b1;
            end
            gap = 1;
        end else if (!sel) begin
            gap++;
        end
        prev_sel = sel; prev_sclk = MP3_SCLK; prev_mosi = MP3_MOSI;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic sdi, input logic [31:0] d);
        frame_t f;
        f.sdi = sdi; f.data = d; f.bits = 32;
        exp_q.push_back(f);
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 3000 && started < n; i++) tick;
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 3000 && obs.size() < n; i++) tick;
        repeat (5) tick;
    endtask

    task automatic run_frames(input int n);
        int s;
        s = started;
        MP3_DREQ = 1'b1;
        wait_starts(s + n);
        MP3_DREQ = 1'b0;
        wait_frames(n);
    endtask

    task automatic test_reset;
        int low;
        frame_t e, o;
        repeat (5) tick;
        checks++;
        if ({MP3_RST, MP3_CS, MP3_DCS, MP3_MOSI, MP3_SCLK, track_done, busy} !== 7'b0110001) begin
            failures++;
            $display("FAIL reset_pins got %b expected 0110001",
                     {MP3_RST, MP3_CS, MP3_DCS, MP3_MOSI, MP3_SCLK, track_done, busy});
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++; $display("FAIL reset_addr got %0d expected 0", mem_addr);
        end
        RST = 1'b1;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (MP3_RST !== 1'b0) break;
            low++;
            tick;
        end
        checks++;
        if (low != HOLD) begin
            failures++; $display("FAIL rst_hold got %0d cycles expected %0d", low, HOLD);
        end
        repeat (40) tick;
        checks++;
        if (started != 0 || busy !== 1'b1) begin
            failures++; $display("FAIL waitreq got frames=%0d busy=%b expected 0 1", started, busy);
        end
        push(1'b0, 32'h0200_0804);
        push(1'b0, 32'h020B_F0F0);
        push(1'b0, 32'h0200_0800);
        run_frames(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL init_frame got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL init_frame got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
        repeat (20) tick;
        checks++;
        if (busy !== 1'b0 || started != 3) begin
            failures++; $display("FAIL idle_after_init got busy=%b frames=%0d expected 0 3", busy, started);
        end
    endtask

    task automatic test_stream;
        frame_t e, o;
        for (int w = 0; w < 2; w++) begin
            push(1'b1, rom(2, w));
            run_frames(1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs.size() == 0) begin
                    failures++; $display("FAIL stream_frame got none expected %h", e.data);
                end else begin
                    o = obs.pop_front();
                    if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                        failures++;
                        $display("FAIL stream_frame got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                                 o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                    end
                end
            end
            checks++;
            if (mem_addr !== AW'(w + 1)) begin
                failures++; $display("FAIL stream_addr got %0d expected %0d", mem_addr, w + 1);
            end
        end
    endtask

    task automatic test_dreq_gap;
        int   r0;
        logic hi;
        frame_t e, o;
        r0 = sclk_rises;
        hi = 1'b1;
        repeat (500) begin
            tick;
            if (MP3_CS !== 1'b1 || MP3_DCS !== 1'b1) hi = 1'b0;
        end
        checks++;
        if (sclk_rises != r0 || !hi) begin
            failures++;
            $display("FAIL dreq_low got edges=%0d selects_high=%b expected 0 1", sclk_rises - r0, hi);
        end
        push(1'b1, rom(2, 2));
        run_frames(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL dreq_resume got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL dreq_resume got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int d0;
        frame_t e, o;
        d0 = done_cnt;
        push(1'b1, rom(2, 3));
        run_frames(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL wrap_frame got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL wrap_frame got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || mem_addr !== '0) begin
            failures++;
            $display("FAIL wrap_done got pulses=%0d addr=%0d expected 1 0", done_cnt - d0, mem_addr);
        end
    endtask

    task automatic test_vol_midframe;
        int s;
        frame_t e, o;
        push(1'b1, rom(2, 0));
        push(1'b0, 32'h020B_2020);
        push(1'b1, rom(2, 1));
        s = started;
        MP3_DREQ = 1'b1;
        wait_starts(s + 1);
        repeat (20) tick;
        vol = 16'h2020;
        wait_starts(s + 3);
        MP3_DREQ = 1'b0;
        wait_frames(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL vol_order got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL vol_order got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
        checks++;
        if (mem_addr !== AW'(2)) begin
            failures++; $display("FAIL vol_addr got %0d expected 2", mem_addr);
        end
    endtask

    task automatic test_pause;
        int s;
        frame_t e, o;
        push(1'b1, rom(2, 2));
        s = started;
        MP3_DREQ = 1'b1;
        wait_starts(s + 1);
        repeat (10) tick;
        pause = 1'b1;
        repeat (400) tick;
        checks++;
        if (started != s + 1 || busy !== 1'b0 || mem_addr !== AW'(3)) begin
            failures++;
            $display("FAIL pause_hold got frames=%0d busy=%b addr=%0d expected 1 0 3",
                     started - s, busy, mem_addr);
        end
        vol = 16'h3030;
        push(1'b0, 32'h020B_3030);
        wait_frames(2);
        checks++;
        if (started != s + 2 || mem_addr !== AW'(3)) begin
            failures++;
            $display("FAIL pause_vol got frames=%0d addr=%0d expected 2 3", started - s, mem_addr);
        end
        push(1'b1, rom(2, 3));
        pause = 1'b0;
        wait_starts(s + 3);
        MP3_DREQ = 1'b0;
        wait_frames(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL pause_frame got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL pause_frame got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++; $display("FAIL pause_resume_addr got %0d expected 0", mem_addr);
        end
    endtask

    task automatic test_track_change;
        int s, d0, low;
        frame_t e, o;
        push(1'b0, 32'h0200_0804);
        push(1'b0, 32'h020B_3030);
        push(1'b0, 32'h0200_0800);
        push(1'b1, rom(5, 0));
        push(1'b1, rom(5, 1));
        s = started;
        MP3_DREQ = 1'b1;
        wait_starts(s + 1);
        repeat (30) tick;
        d0 = done_cnt;
        track_sel = 3'd5;
        tick;
        checks++;
        if ({MP3_RST, MP3_CS, MP3_DCS} !== 3'b011 || mem_addr !== '0) begin
            failures++;
            $display("FAIL trk_reset got rst/cs/dcs=%b addr=%0d expected 011 0",
                     {MP3_RST, MP3_CS, MP3_DCS}, mem_addr);
        end
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (MP3_RST !== 1'b0) break;
            low++;
            tick;
        end
        checks++;
        if (low != HOLD) begin
            failures++; $display("FAIL trk_rst_hold got %0d cycles expected %0d", low, HOLD);
        end
        wait_starts(s + 6);
        MP3_DREQ = 1'b0;
        wait_frames(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL trk_frame got none expected %h", e.data);
            end else begin
                o = obs.pop_front();
                if (o.sdi !== e.sdi || o.data !== e.data || o.bits != e.bits) begin
                    failures++;
                    $display("FAIL trk_frame got sdi=%b %h bits=%0d expected sdi=%b %h bits=%0d",
                             o.sdi, o.data, o.bits, e.sdi, e.data, e.bits);
                end
            end
        end
        checks++;
        if (done_cnt != d0 || mem_addr !== AW'(2)) begin
            failures++;
            $display("FAIL trk_tail got pulses=%0d addr=%0d expected 0 2", done_cnt - d0, mem_addr);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_dreq_gap;
        test_wrap;
        test_vol_midframe;
        test_pause;
        test_track_change;
        checks++;
        if (proto_err != 0) begin
            failures++; $display("FAIL spi_protocol got %0d violations expected 0", proto_err);
        end
        checks++;
        if (timing_err != 0) begin
            failures++; $display("FAIL spi_timing got %0d violations expected 0", timing_err);
        end
        checks++;
        if (obs.size() != 0) begin
            failures++; $display("FAIL extra_frames got %0d expected 0", obs.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
